// File: rtl/sipo_pkg.sv
// Shared definitions for the serial-in, parallel-out receiver:
// FSM state encodings and the default word width.
package sipo_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/sipo_shift_reg.sv
// Shift register and bit counter for one serial frame; flags the edge that
// samples the final bit and presents the completed word on that same edge.
module sipo_shift_reg
  import sipo_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin_i,
  input  logic             capture_i,
  input  logic             shift_i,
  output logic             done_o,
  output logic [WIDTH-1:0] word_o
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] captured;
  logic [CW-1:0]    count_q, count_d;

  // A capture always restarts the frame, even mid-word; completion clears the
  // register so the next frame starts from a clean slate.
  always_comb begin
    if (MSB_FIRST) begin
      shifted  = {shift_q[WIDTH-2:0], sin_i};
      captured = {{(WIDTH-1){1'b0}}, sin_i};
    end else begin
      shifted  = {sin_i, shift_q[WIDTH-1:1]};
      captured = {sin_i, {(WIDTH-1){1'b0}}};
    end
    done_o  = shift_i && (count_q == CW'(WIDTH - 1));
    word_o  = shifted;
    shift_d = shift_q;
    count_d = count_q;
    if (capture_i) begin
      shift_d = captured;
      count_d = CW'(1);
    end else if (done_o) begin
      shift_d = '0;
      count_d = '0;
    end else if (shift_i) begin
      shift_d = shifted;
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
      count_q <= '0;
    end else begin
      shift_q <= shift_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/sipo_receiver.sv
// Serial-to-parallel receiver: frame FSM, output word register with
// valid/ready handshake and a sticky overrun flag for dropped words.
module sipo_receiver
  import sipo_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             sin_start,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic             overrun
);

  state_e           state_q;
  logic [WIDTH-1:0] dout_q;
  logic             dout_valid_q;
  logic             busy_q;
  logic             overrun_q;

  logic             capture;
  logic             shift_en;
  logic             done;
  logic [WIDTH-1:0] word;

  assign capture  = sin_valid && sin_start;
  assign shift_en = sin_valid && !sin_start && (state_q == SHIFT);

  sipo_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .clk       (clk),
    .rst       (rst),
    .sin_i     (sin),
    .capture_i (capture),
    .shift_i   (shift_en),
    .done_o    (done),
    .word_o    (word)
  );

  // A completed word is only dropped when an unconsumed word is still held
  // and the consumer is not taking it on this very edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      if (capture) begin
        state_q <= SHIFT;
        busy_q  <= 1'b1;
      end else if (done) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end
      if (done) begin
        if (!dout_valid_q || dout_ready) begin
          dout_q       <= word;
          dout_valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (dout_valid_q && dout_ready) begin
        dout_valid_q <= 1'b0;
      end
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_sipo_receiver.sv
// Directed bench for sipo_receiver: an MSB-first and an LSB-first instance
// share one serial stream; expected words are queued when frames are driven.
module tb_sipo_receiver;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sin = 1'b0;
  logic         sin_valid = 1'b0;
  logic         sin_start = 1'b0;
  logic         dout_ready = 1'b1;
  logic [W-1:0] doutM, doutL;
  logic         validM, validL, busyM, busyL, ovM, ovL;

  int checks = 0;
  int errors = 0;

  logic         lastBit = 1'b0;
  logic         mValid = 1'b0;
  logic         mOverrun = 1'b0;
  logic [W-1:0] expM[$];
  logic [W-1:0] expL[$];
  logic [W-1:0] curM = '0;
  logic [W-1:0] curL = '0;

  sipo_receiver #(.WIDTH(W), .MSB_FIRST(1'b1)) dutM (
    .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .sin_start(sin_start),
    .dout(doutM), .dout_valid(validM), .dout_ready(dout_ready), .busy(busyM), .overrun(ovM)
  );

  sipo_receiver #(.WIDTH(W), .MSB_FIRST(1'b0)) dutL (
    .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .sin_start(sin_start),
    .dout(doutL), .dout_valid(validL), .dout_ready(dout_ready), .busy(busyL), .overrun(ovL)
  );

  always #5 clk = ~clk;

  // Handshake reference: the bench marks the final bit of each frame itself.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mValid   <= 1'b0;
      mOverrun <= 1'b0;
    end else if (sin_valid && lastBit) begin
      if (!mValid || dout_ready) mValid <= 1'b1;
      else mOverrun <= 1'b1;
    end else if (mValid && dout_ready) begin
      mValid <= 1'b0;
    end
  end

  function automatic logic [W-1:0] rev(input logic [W-1:0] x);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = x[W-1-i];
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at the next falling edge after sampling.
  task automatic applyStimulus(input logic b, input logic st, input logic last);
    sin       = b;
    sin_start = st;
    lastBit   = last;
    sin_valid = 1'b1;
    @(negedge clk);
    sin_valid = 1'b0;
    sin_start = 1'b0;
    sin       = 1'b0;
    lastBit   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sendFrame(input logic [W-1:0] w, input bit gaps, input bit readyLast, input bit chkBusy);
    int g;
    for (int i = 0; i < W; i++) begin
      if (gaps && i > 0) begin
        g = $urandom_range(0, 4);
        for (int k = 0; k < g; k++) begin
          @(negedge clk);
          if (chkBusy) checkOutput("busy_gap", {31'd0, busyM}, 32'd1);
        end
      end
      if (i == W - 1) begin
        if (readyLast) dout_ready = 1'b1;
        if (!mValid || dout_ready) begin
          expM.push_back(w);
          expL.push_back(rev(w));
        end
      end
      applyStimulus(w[W-1-i], (i == 0), (i == W - 1));
      if (chkBusy) checkOutput("busy_bit", {31'd0, busyM}, (i < W - 1) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic checkFrame(input string tag);
    if (expM.size() > 0) begin
      curM = expM.pop_front();
      curL = expL.pop_front();
    end
    checkOutput({tag, "_doutM"}, {24'd0, doutM}, {24'd0, curM});
    checkOutput({tag, "_doutL"}, {24'd0, doutL}, {24'd0, curL});
    checkOutput({tag, "_valid"}, {31'd0, validM}, {31'd0, mValid});
    checkOutput({tag, "_validL"}, {31'd0, validL}, {31'd0, mValid});
    checkOutput({tag, "_overrun"}, {31'd0, ovM}, {31'd0, mOverrun});
    checkOutput({tag, "_busy"}, {31'd0, busyM}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    dout_ready = 1'b1;
    idle(2);
    checkOutput("rst_dout", {24'd0, doutM}, 32'd0);
    checkOutput("rst_valid", {31'd0, validM}, 32'd0);
    checkOutput("rst_busy", {31'd0, busyM}, 32'd0);
    checkOutput("rst_overrun", {31'd0, ovM}, 32'd0);
    rst = 1'b0;

    // Start accepted on the first edge after reset; reset mid-frame
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("first_edge_busy", {31'd0, busyM}, 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_busy", {31'd0, busyM}, 32'd0);
    checkOutput("midrst_valid", {31'd0, validM}, 32'd0);
    checkOutput("midrst_dout", {24'd0, doutM}, 32'd0);
    curM = '0;
    curL = '0;
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("nostart_ignored", {31'd0, busyM}, 32'd0);
    sendFrame(8'h5A, 1'b0, 1'b0, 1'b0);
    checkFrame("after_rst_5a");
    idle(2);

    // Back-to-back bits, consumer ready: valid for exactly one cycle
    sendFrame(8'hA5, 1'b0, 1'b0, 1'b1);
    checkFrame("a5");
    @(negedge clk);
    checkOutput("a5_valid_one_cycle", {31'd0, validM}, 32'd0);
    checkOutput("a5_dout_hold", {24'd0, doutM}, 32'hA5);
    idle(2);

    sendFrame(8'hA5, 1'b1, 1'b0, 1'b1);
    checkFrame("a5_gaps");
    idle(2);

    // Overrun: second word dropped while first is unconsumed
    dout_ready = 1'b0;
    sendFrame(8'h3C, 1'b0, 1'b0, 1'b0);
    checkFrame("ovr_first");
    sendFrame(8'hC3, 1'b1, 1'b0, 1'b0);
    checkFrame("ovr_second");
    idle(3);
    checkOutput("ovr_hold_valid", {31'd0, validM}, 32'd1);
    dout_ready = 1'b1;
    @(negedge clk);
    checkOutput("ovr_accept_valid", {31'd0, validM}, 32'd0);
    checkOutput("ovr_sticky", {31'd0, ovM}, 32'd1);
    checkOutput("ovr_dout_hold", {24'd0, doutM}, 32'h3C);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    curM = '0;
    curL = '0;
    checkOutput("ovr_cleared_by_rst", {31'd0, ovM}, 32'd0);

    // Completion with valid held and consumer accepting on the same edge
    dout_ready = 1'b0;
    sendFrame(8'h11, 1'b0, 1'b0, 1'b0);
    checkFrame("pass_first");
    sendFrame(8'h22, 1'b0, 1'b1, 1'b0);
    checkFrame("pass_second");
    @(negedge clk);
    checkOutput("pass_consumed", {31'd0, validM}, 32'd0);

    // Restart mid-frame discards the partial word
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    sendFrame(8'h0F, 1'b0, 1'b0, 1'b0);
    checkFrame("restart_0f");
    idle(3);
    checkOutput("restart_single_word", {31'd0, validM}, 32'd0);

    // Bit ordering
    sendFrame(8'h80, 1'b0, 1'b0, 1'b0);
    checkFrame("order");
    checkOutput("order_msb_first", {24'd0, doutM}, 32'h80);
    checkOutput("order_lsb_first", {24'd0, doutL}, 32'h01);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sipo_receiver.md
SIPO_RECEIVER -- requirements
Module: sipo_receiver

Interface
REQ-001 Parameter WIDTH, default 8: parallel word width; the block SHALL support values from 2 to 32.
REQ-002 Parameter MSB_FIRST, default 1: 1 = first serial bit lands in dout[WIDTH-1]; 0 = first serial bit lands in dout[0].
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 Port sin, input, 1 bit: serial data bit, sampled only when sin_valid=1.
REQ-006 Port sin_valid, input, 1 bit: bit strobe; the block SHALL sample sin on each rising edge where sin_valid=1.
REQ-007 Port sin_start, input, 1 bit: marks the first bit of a frame; it SHALL be honoured only when sin_valid=1.
REQ-008 Port dout, output, WIDTH bits: last completed word.
REQ-009 Port dout_valid, output, 1 bit: dout holds an unconsumed word.
REQ-010 Port dout_ready, input, 1 bit: consumer accept; the word transfers on an edge where dout_valid=1 and dout_ready=1.
REQ-011 Port busy, output, 1 bit: high while a frame is partially received (FSM in SHIFT).
REQ-012 Port overrun, output, 1 bit: sticky flag for a dropped completed word.

Function
REQ-013 FSM states: IDLE and SHIFT; the bit counter SHALL be $clog2(WIDTH+1) bits wide.
REQ-014 IDLE: sin_valid=1 with sin_start=0 SHALL be ignored.
REQ-015 IDLE, sin_valid=1 with sin_start=1: capture sin, set count=1, go to SHIFT.
REQ-016 SHIFT, sin_valid=1 with sin_start=0: shift sin in per MSB_FIRST and increment count.
REQ-017 SHIFT, sin_valid=0: hold all state; gaps of any length between bits are legal.
REQ-018 Word completion: on the edge sampling bit number WIDTH, the completed word SHALL be offered to the output register and the FSM SHALL go to IDLE.
REQ-019 Latency: dout_valid SHALL be high in the cycle immediately after the edge sampling the last bit.
REQ-020 The shift register and the output register are separate, so the next frame may be received while dout_valid=1.
REQ-021 Accept only: on an edge with dout_valid=1, dout_ready=1 and no completion, dout_valid SHALL clear.
REQ-022 Completion while dout_valid=0: load dout with the new word and set dout_valid.
REQ-023 Completion while dout_valid=1 and dout_ready=1: load dout with the new word; dout_valid SHALL stay 1.
REQ-024 Completion while dout_valid=1 and dout_ready=0: drop the new word, leave dout unchanged and set overrun.
REQ-025 overrun SHALL clear only on reset.
REQ-026 SHIFT, sin_valid=1 with sin_start=1: discard the partial word, capture sin as bit 1, set count=1 and stay in SHIFT.
REQ-027 dout SHALL change only on a load; it SHALL hold its value after it is consumed.

Reset
REQ-028 rst=1 SHALL immediately force: FSM=IDLE, count=0, shift register=0, dout=0, dout_valid=0, busy=0, overrun=0.
REQ-029 Reset mid-frame SHALL discard the partial word; the first frame after reset SHALL require sin_start.
REQ-030 After rst falls, the block SHALL accept sin_start on the first rising edge.

Structure
REQ-031 Shared package sipo_pkg SHALL hold the FSM state encodings (IDLE=0, SHIFT=1) and the default WIDTH.
REQ-032 Sub-module sipo_shift_reg (WIDTH, MSB_FIRST) SHALL contain the shift register and bit counter; the top level SHALL hold the FSM, output register and handshake.

Verification
REQ-033 Reset: WIDTH=8, rst pulsed after 3 bits -> all outputs 0; a fresh frame of 0x5A then completes correctly.
REQ-034 MSB_FIRST=1, dout_ready=1, bits 1,0,1,0,0,1,0,1 with sin_start on bit 1 -> dout=0xA5 and dout_valid high exactly one cycle.
REQ-035 Same frame with random 0-4 cycle gaps on sin_valid -> dout=0xA5; busy high from bit 1 through bit 7.
REQ-036 dout_ready=0, frames 0x3C then 0xC3 -> dout stays 0x3C, overrun=1; after dout_ready=1, dout_valid clears.
REQ-037 sin_start reasserted after 3 bits, then bits of 0x0F -> single word 0x0F; no overrun.
REQ-038 MSB_FIRST=0, bits 1,0,0,0,0,0,0,0 -> dout=0x01; with MSB_FIRST=1 the same bits -> dout=0x80.
